// File: rtl/serial_pattern_tx_pkg.sv
// Shared state encoding for serial_pattern_tx; {q1,q0} expose these values directly.
package serial_pattern_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_PAR   = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/serial_pattern_tx_piso.sv
// piso_shift: parallel-in/serial-out register, MSB first, zero-filled from the LSB end.
module piso_shift #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data,
  output logic             msb,
  output logic             msb_nxt
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sreg <= '0;
    else if (load)
      sreg <= data;
    else if (shift_en)
      sreg <= {sreg[WIDTH-2:0], 1'b0};
  end

  assign msb     = sreg[WIDTH-1];
  // Bit that becomes the MSB after the next shift; lets x be registered.
  assign msb_nxt = sreg[WIDTH-2];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: WIDTH-bit frame out MSB-first on x, done pulse at end.
// Define SERIAL_PATTERN_TX_PARITY_EN to append an even-parity bit after the data bits.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             done,
  output logic             q1,
  output logic             q0
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             par, par_nxt;
  logic             ld, shift_en;
  logic             msb, msb_nxt;
  logic             ready_nxt, x_nxt, x_valid_nxt, done_nxt;

  piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .shift_en (shift_en),
    .data     (data),
    .msb      (msb),
    .msb_nxt  (msb_nxt)
  );

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    shift_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          ld        = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (cnt == '0) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          state_nxt = ST_PAR;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      ST_PAR:  state_nxt = ST_DONE;
`endif
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops alongside it.
  always_comb begin
    ready_nxt   = 1'b0;
    x_nxt       = 1'b0;
    x_valid_nxt = 1'b0;
    done_nxt    = 1'b0;
    par_nxt     = par;
    if (ld)
      par_nxt = 1'b0;
    else if (shift_en)
      par_nxt = par ^ msb;
    case (state_nxt)
      ST_IDLE:  ready_nxt = 1'b1;
      ST_SHIFT: begin
        x_valid_nxt = 1'b1;
        x_nxt       = ld ? data[WIDTH-1] : msb_nxt;
      end
      ST_PAR: begin
        x_valid_nxt = 1'b1;
        x_nxt       = par_nxt;
      end
      ST_DONE:  done_nxt = 1'b1;
      default:  ready_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      par     <= 1'b0;
      ready   <= 1'b1;
      x       <= 1'b0;
      x_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      par     <= par_nxt;
      ready   <= ready_nxt;
      x       <= x_nxt;
      x_valid <= x_valid_nxt;
      done    <= done_nxt;
      if (ld)
        cnt <= CNT_W'(WIDTH - 1);
      else if (shift_en && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  assign q1 = state[1];
  assign q0 = state[0];

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: vector table of frames plus handshake/reset corner sequences.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load, load2;
  logic [7:0] data;
  logic [1:0] data2;
  logic       ready, x, x_valid, done, q1, q0;
  logic       ready2, x2, x_valid2, done2, q1_2, q0_2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(8), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .ready(ready),
    .x(x), .x_valid(x_valid), .done(done), .q1(q1), .q0(q0)
  );

  serial_pattern_tx #(.WIDTH(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .load(load2), .data(data2), .ready(ready2),
    .x(x2), .x_valid(x_valid2), .done(done2), .q1(q1_2), .q0(q0_2)
  );

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ready"},   int'(ready),   1);
    check({tag, " x_valid"}, int'(x_valid), 0);
    check({tag, " done"},    int'(done),    0);
    check({tag, " x"},       int'(x),       0);
    check({tag, " state"},   int'({q1, q0}), 0);
  endtask

  // Called right after a negedge; returns at the negedge of the IDLE cycle after done.
  task automatic frame8(input logic [7:0] d, input logic ep, input bit hold, input bit inject);
    load = 1'b1;
    data = d;
    @(negedge clk);
    if (!hold) load = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      check("bit x",       int'(x),        int'(d[i]));
      check("bit x_valid", int'(x_valid),  1);
      check("bit ready",   int'(ready),    0);
      check("bit done",    int'(done),     0);
      check("bit state",   int'({q1, q0}), 1);
      if (inject) begin
        load = (i == 5);
        data = 8'hFF;
      end
      @(negedge clk);
    end
    if (inject) load = 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    check("par x",       int'(x),        int'(ep));
    check("par x_valid", int'(x_valid),  1);
    check("par state",   int'({q1, q0}), 2);
    @(negedge clk);
`endif
    check("done pulse",   int'(done),     1);
    check("done x_valid", int'(x_valid),  0);
    check("done ready",   int'(ready),    0);
    check("done state",   int'({q1, q0}), 3);
    @(negedge clk);
    check("post ready",   int'(ready),    1);
    check("post done",    int'(done),     0);
    check("post state",   int'({q1, q0}), 0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h0F, 1'b0};
    vecs[2] = '{8'h81, 1'b0};
    vecs[3] = '{8'h01, 1'b1};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'hFF, 1'b0};
    vecs[6] = '{8'h00, 1'b0};
    vecs[7] = '{8'h7E, 1'b0};
    vecs[8] = '{8'h13, 1'b1};
    vecs[9] = '{8'h6D, 1'b1};

    rst_n = 1'b0;
    load  = 1'b0;
    load2 = 1'b0;
    data  = 8'h00;
    data2 = 2'b00;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset2 ready", int'(ready2), 1);
    check("reset2 state", int'({q1_2, q0_2}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("idle");

    foreach (vecs[i]) frame8(vecs[i].data, vecs[i].exp_par, 1'b0, 1'b0);

    // load pulsed mid-frame is ignored and does not disturb the captured pattern
    frame8(8'h0F, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_idle("no queued frame");

    // load held high: two frames with a single IDLE cycle between them
    frame8(8'h81, 1'b0, 1'b1, 1'b0);
    frame8(8'h81, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_idle("after b2b");

    // asynchronous reset in the middle of a frame
    load = 1'b1;
    data = 8'hC3;
    @(negedge clk);
    load = 1'b0;
    for (int i = 7; i >= 4; i--) begin
      check("pre-reset x", int'(x), int'(data[i]));
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 check_idle("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check("no done after reset", int'(done), 0);
      check("stay idle", int'(ready), 1);
      @(negedge clk);
    end

    // minimum width
    load2 = 1'b1;
    data2 = 2'b10;
    @(negedge clk);
    load2 = 1'b0;
    data2 = 2'b01;
    check("w2 bit1",    int'(x2), 1);
    check("w2 valid1",  int'(x_valid2), 1);
    check("w2 state1",  int'({q1_2, q0_2}), 1);
    @(negedge clk);
    check("w2 bit0",    int'(x2), 0);
    check("w2 valid0",  int'(x_valid2), 1);
    @(negedge clk);
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    check("w2 par",     int'(x2), 1);
    check("w2 parvld",  int'(x_valid2), 1);
    @(negedge clk);
`endif
    check("w2 done",    int'(done2), 1);
    check("w2 dstate",  int'({q1_2, q0_2}), 3);
    @(negedge clk);
    check("w2 ready",   int'(ready2), 1);
    check("w2 nodone",  int'(done2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
